// File: rtl/joypad_cfg_uart_tx.sv
// UART 8N1 transmitter feeding the gamepad's serial config input. Queues joypad config bytes
// and generic host bytes in a small FIFO so consecutive frames leave back to back.
module joypad_cfg_uart_tx #(
  parameter int unsigned CLK_HZ     = 24000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk24_i,
  input  logic                          rst_i,
  input  logic [7:0]                    cfg_data_i,
  input  logic                          cfg_upd_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          uart_tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o
);

  localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = AW + 1;

  localparam logic [CW-1:0] CntLast   = CW'(DIV - 1);
  localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          overflow_q;

  logic       fifo_empty;
  logic       fifo_full;
  logic       baud_last;
  logic       pop;
  logic       can_push;
  logic       push;
  logic [7:0] push_data;
  logic [7:0] head;

  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LevelFull);
    baud_last  = (baud_q == CntLast);
    // The FSM takes the head byte either from idle or on the last stop-bit cycle.
    pop        = !fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && baud_last));
    // A pop on this edge frees a slot, so a full FIFO can still accept.
    can_push   = !fifo_full || pop;
    tx_ready_o = can_push && !cfg_upd_i;
    push       = can_push && (cfg_upd_i || tx_valid_i);
    push_data  = cfg_upd_i ? cfg_data_i : tx_data_i;
    head       = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk24_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk24_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
      if (cfg_upd_i && !can_push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk24_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            shift_q <= head;
            tx_q    <= 1'b0;
            baud_q  <= '0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            state_q <= StData;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StStop: begin
          if (baud_last) begin
            baud_q <= '0;
            // Chain straight into the next start bit when more bytes are waiting.
            if (pop) begin
              shift_q <= head;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign uart_tx_o    = tx_q;
  assign busy_o       = (state_q != StIdle) || !fifo_empty;
  assign fifo_level_o = level_q;
  assign overflow_o   = overflow_q;

endmodule
